// File: rtl/btr_arb.sv
// btr_arb: two-port arbiter that serialises access to one 16-bit bit-reverse network.
// Optional build macro BTR_ARB_FIXED_PRIO_EN: port 0 always wins contention and no round-robin state is kept.
module btr_arb #(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  input  logic [N-1:0] req0_data,
  output logic         req0_ready,
  input  logic         req1_valid,
  input  logic [N-1:0] req1_data,
  output logic         req1_ready,
  output logic         rsp_valid,
  output logic [N-1:0] rsp_data,
  output logic         rsp_id,
  input  logic         rsp_ready
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t       state_p0;
  logic [N-1:0] data_p0;
  logic         id_p0;
  logic         free;
  logic         gnt0;
  logic         gnt1;
  logic         acc;
  logic [N-1:0] acc_data;

  function automatic logic [N-1:0] bit_reverse(input logic [N-1:0] d);
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = d[N-1-i];
    return r;
  endfunction

  // The result register can take a new operand when empty or being drained this cycle.
  assign free = (state_p0 == EMPTY) || rsp_ready;

`ifdef BTR_ARB_FIXED_PRIO_EN
  assign gnt0 = free && req0_valid;
  assign gnt1 = free && req1_valid && !req0_valid;
`else
  logic last_p0;
  assign gnt0 = free && req0_valid && (!req1_valid || last_p0);
  assign gnt1 = free && req1_valid && (!req0_valid || !last_p0);
`endif

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign acc        = gnt0 || gnt1;
  assign acc_data   = gnt0 ? req0_data : req1_data;

  // Stage p0: result register, written only on accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_p0 <= EMPTY;
      data_p0  <= '0;
      id_p0    <= 1'b0;
`ifndef BTR_ARB_FIXED_PRIO_EN
      last_p0  <= 1'b1;
`endif
    end else begin
      case (state_p0)
        EMPTY:   if (acc) state_p0 <= FULL;
        FULL:    if (rsp_ready && !acc) state_p0 <= EMPTY;
        default: state_p0 <= EMPTY;
      endcase
      if (acc) begin
        data_p0 <= bit_reverse(acc_data);
        id_p0   <= gnt1;
`ifndef BTR_ARB_FIXED_PRIO_EN
        last_p0 <= gnt1;
`endif
      end
    end
  end

  assign rsp_valid = (state_p0 == FULL);
  assign rsp_data  = data_p0;
  assign rsp_id    = id_p0;

endmodule

// File: tb/tb_btr_arb.sv
// Testbench for btr_arb: directed scenarios plus randomized traffic, checked by a
// queue-based scoreboard fed from a transaction-level arbitration model.
module tb_btr_arb;

  logic        clk;
  logic        rst_n;
  logic        req0_valid;
  logic [15:0] req0_data;
  logic        req0_ready;
  logic        req1_valid;
  logic [15:0] req1_data;
  logic        req1_ready;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic        rsp_id;
  logic        rsp_ready;

  btr_arb #(.N(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_id(rsp_id), .rsp_ready(rsp_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        id;
    logic [15:0] data;
  } exp_t;

  exp_t exp_q[$];
  logic got_id[$];
  logic [15:0] got_data[$];
  int got_cyc[$];

  int checks = 0;
  int failures = 0;
  int mon_cyc = 0;

  bit m_full = 1'b0;
  bit m_last = 1'b1;
  bit g0 = 1'b0;
  bit g1 = 1'b0;
  bit acc0 = 1'b0;
  bit acc1 = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] ref_rev(input logic [15:0] d);
    logic [15:0] r;
    r = 16'h0;
    for (int i = 0; i < 16; i++) r = (r << 1) | ((d >> i) & 16'h1);
    return r;
  endfunction

  // Reference model: decides grants from the arbitration rules and queues expected results.
  always begin
    @(negedge clk);
    #1;
    if (!rst_n) begin
      m_full = 1'b0;
      m_last = 1'b1;
      acc0   = 1'b0;
      acc1   = 1'b0;
    end else begin
      g0 = 1'b0;
      g1 = 1'b0;
      if (!m_full || rsp_ready) begin
        if (req0_valid && req1_valid) begin
`ifdef BTR_ARB_FIXED_PRIO_EN
          g0 = 1'b1;
`else
          if (m_last) g0 = 1'b1;
          else        g1 = 1'b1;
`endif
        end else begin
          g0 = req0_valid;
          g1 = req1_valid;
        end
      end
      chk("req0_ready", {31'b0, req0_ready}, {31'b0, g0});
      chk("req1_ready", {31'b0, req1_ready}, {31'b0, g1});
      if (g0) begin
        exp_q.push_back(exp_t'{id: 1'b0, data: ref_rev(req0_data)});
        m_last = 1'b0;
      end
      if (g1) begin
        exp_q.push_back(exp_t'{id: 1'b1, data: ref_rev(req1_data)});
        m_last = 1'b1;
      end
      m_full = g0 || g1 || (m_full && !rsp_ready);
      acc0 = g0;
      acc1 = g1;
    end
  end

  // Monitor: compares whatever the DUT presents against the head of the scoreboard.
  always @(negedge clk) begin
    mon_cyc++;
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      chk("rsp_valid", {31'b0, rsp_valid}, {31'b0, exp_q.size() != 0});
      if (rsp_valid && exp_q.size() != 0) begin
        chk("rsp_data", {16'b0, rsp_data}, {16'b0, exp_q[0].data});
        chk("rsp_id", {31'b0, rsp_id}, {31'b0, exp_q[0].id});
        if (rsp_ready) begin
          got_id.push_back(rsp_id);
          got_data.push_back(rsp_data);
          got_cyc.push_back(mon_cyc);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic setin(input bit v0, input logic [15:0] d0, input bit v1,
                       input logic [15:0] d1, input bit rr);
    req0_valid = v0;
    req0_data  = d0;
    req1_valid = v1;
    req1_data  = d1;
    rsp_ready  = rr;
  endtask

  task automatic drive(input bit v0, input logic [15:0] d0, input bit v1,
                       input logic [15:0] d1, input bit rr);
    setin(v0, d0, v1, d1, rr);
    @(posedge clk);
    #1;
  endtask

  task automatic logchk(input string name, input int idx, input logic exp_id,
                        input logic [15:0] exp_data);
    if (idx >= got_id.size()) begin
      chk({name, "_count"}, got_id.size(), idx + 1);
    end else begin
      chk({name, "_id"}, {31'b0, got_id[idx]}, {31'b0, exp_id});
      chk({name, "_data"}, {16'b0, got_data[idx]}, {16'b0, exp_data});
    end
  endtask

  initial begin
    int base;
    logic [15:0] held;
    logic exp_id;

    rst_n = 1'b0;
    setin(0, 16'h0, 0, 16'h0, 0);
    #1;
    chk("reset_rsp_valid", {31'b0, rsp_valid}, 0);
    chk("reset_rsp_data", {16'b0, rsp_data}, 0);
    chk("reset_rsp_id", {31'b0, rsp_id}, 0);
    #22;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Fill the result register, then reset asynchronously while FULL.
    drive(1, 16'h0003, 0, 16'h0, 0);
    setin(0, 16'h0, 0, 16'h0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_rsp_valid", {31'b0, rsp_valid}, 0);
    chk("async_reset_rsp_data", {16'b0, rsp_data}, 0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Contention right after reset.
    base = got_id.size();
    for (int k = 0; k < 4; k++) drive(1, 16'h00F0, 1, 16'h1234, 1);
    drive(0, 16'h0, 0, 16'h0, 1);
    for (int k = 0; k < 4; k++) begin
`ifdef BTR_ARB_FIXED_PRIO_EN
      exp_id = 1'b0;
`else
      exp_id = k[0];
`endif
      logchk("contention", base + k, exp_id, exp_id ? 16'h2C48 : 16'h0F00);
    end

    // Single request.
    base = got_id.size();
    drive(1, 16'h0001, 0, 16'h0, 1);
    drive(0, 16'h0, 0, 16'h0, 1);
    @(negedge clk);
    chk("single_drain_valid", {31'b0, rsp_valid}, 0);
    @(posedge clk);
    #1;
    logchk("single", base, 1'b0, 16'h8000);

    // Backpressure while FULL, with port 1 pending.
    base = got_id.size();
    drive(1, 16'h1111, 0, 16'h0, 0);
    for (int k = 0; k < 3; k++) begin
      setin(0, 16'h0, 1, 16'h2222, 0);
      @(negedge clk);
      held = rsp_data;
      chk("bp_data", {16'b0, held}, {16'b0, 16'h8888});
      chk("bp_id", {31'b0, rsp_id}, 0);
      chk("bp_ready1", {31'b0, req1_ready}, 0);
      @(posedge clk);
      #1;
    end
    setin(0, 16'h0, 1, 16'h2222, 1);
    @(negedge clk);
    chk("bp_release_ready1", {31'b0, req1_ready}, 1);
    @(posedge clk);
    #1;
    drive(0, 16'h0, 0, 16'h0, 1);
    logchk("bp_first", base, 1'b0, 16'h8888);
    logchk("bp_second", base + 1, 1'b1, 16'h4444);

    // Back-to-back stream from port 1.
    base = got_id.size();
    drive(0, 16'h0, 1, 16'hFFFF, 1);
    drive(0, 16'h0, 1, 16'hA5A5, 1);
    drive(0, 16'h0, 1, 16'h0000, 1);
    drive(0, 16'h0, 0, 16'h0, 1);
    logchk("b2b_0", base, 1'b1, 16'hFFFF);
    logchk("b2b_1", base + 1, 1'b1, 16'hA5A5);
    logchk("b2b_2", base + 2, 1'b1, 16'h0000);
    if (got_cyc.size() >= base + 3) begin
      chk("b2b_gap_a", got_cyc[base + 1] - got_cyc[base], 1);
      chk("b2b_gap_b", got_cyc[base + 2] - got_cyc[base + 1], 1);
    end else begin
      chk("b2b_gap_count", got_cyc.size(), base + 3);
    end

    // Idle cycles must not move the round-robin pointer.
    base = got_id.size();
    drive(0, 16'h0, 1, 16'h0F0F, 1);
    for (int k = 0; k < 5; k++) drive(0, 16'h0, 0, 16'h0, 1);
    drive(1, 16'h0001, 1, 16'h0002, 1);
    drive(0, 16'h0, 0, 16'h0, 1);
    logchk("idle_p1", base, 1'b1, 16'hF0F0);
    logchk("idle_contend", base + 1, 1'b0, 16'h8000);

    // Randomized traffic honouring the hold-until-ready protocol.
    for (int c = 0; c < 3000; c++) begin
      if (!req0_valid || acc0) begin
        req0_valid = ($urandom_range(0, 2) != 0);
        req0_data  = 16'($urandom);
      end
      if (!req1_valid || acc1) begin
        req1_valid = ($urandom_range(0, 2) != 0);
        req1_data  = 16'($urandom);
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      #1;
    end
    drive(0, 16'h0, 0, 16'h0, 1);
    drive(0, 16'h0, 0, 16'h0, 1);
    chk("final_queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
